sharpened_frame_sink: RTL and testbench



---
 rtl/sharpened_frame_sink.sv | 201 ++++++++++++++++++++
 tb/tb_sharpened_frame_sink.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sharpened_frame_sink.sv
// Captures one frame of signed filter results, saturated to PIX_W bits, then replays it in raster order.
// Optional clip counter enabled by defining SINK_CLIP_COUNT_EN; otherwise clip_count is tied to zero.
module sharpened_frame_sink #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned IN_W  = 10,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_pixel,
  input  logic             in_en,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eol,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy,
  output logic             overflow_err,
  output logic [15:0]      clip_count
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [0:0] ST_CAPTURE = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << PIX_W) - 1);

  logic [PIX_W-1:0] mem_q [NPIX];

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [CW-1:0]    rd_col_q, rd_col_d;
  logic             fetch_done_q, fetch_done_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_valid_q, out_valid_d;
  logic             out_eol_q, out_eol_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic             clip_lo_c, clip_hi_c;
  logic [PIX_W-1:0] sat_pix_c;
  logic             wr_en_c;
  logic             accept_c;
  logic             frame_end_c;

  // Signed saturation of the incoming sample to [0, 2^PIX_W-1]
  always_comb begin
    clip_lo_c = in_pixel[IN_W-1];
    clip_hi_c = !clip_lo_c && ($signed(in_pixel) > SAT_MAX);
    sat_pix_c = in_pixel[PIX_W-1:0];
    if (clip_lo_c) begin
      sat_pix_c = '0;
    end else if (clip_hi_c) begin
      sat_pix_c = '1;
    end
  end

  // Next-state and output logic for capture/drain
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_col_d     = rd_col_q;
    fetch_done_d = fetch_done_q;
    out_pixel_d  = out_pixel_q;
    out_valid_d  = out_valid_q;
    out_eol_d    = out_eol_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    wr_en_c      = 1'b0;
    frame_end_c  = 1'b0;
    accept_c     = out_valid_q && out_ready;
    overflow_d   = overflow_q || (in_en && (state_q == ST_DRAIN));

    case (state_q)
      ST_CAPTURE: begin
        if (in_en) begin
          wr_en_c = 1'b1;
          if (wr_addr_q == AW'(NPIX - 1)) begin
            wr_addr_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (accept_c) begin
          out_valid_d = 1'b0;
        end
        if (accept_c && out_last_q) begin
          frame_end_c  = 1'b1;
          state_d      = ST_CAPTURE;
          frame_done_d = 1'b1;
          rd_addr_d    = '0;
          rd_col_d     = '0;
          fetch_done_d = 1'b0;
          out_eol_d    = 1'b0;
          out_last_d   = 1'b0;
        end else if (!fetch_done_q && (!out_valid_q || out_ready)) begin
          // Output register is free (or being freed): load the next buffered pixel
          out_pixel_d = mem_q[rd_addr_q];
          out_valid_d = 1'b1;
          out_eol_d   = (rd_col_q == CW'(IMG_W - 1));
          out_last_d  = (rd_addr_q == AW'(NPIX - 1));
          rd_col_d    = (rd_col_q == CW'(IMG_W - 1)) ? '0 : rd_col_q + CW'(1);
          if (rd_addr_q == AW'(NPIX - 1)) begin
            fetch_done_d = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = ST_CAPTURE;
      end
    endcase

    busy_d = (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CAPTURE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_col_q     <= '0;
      fetch_done_q <= 1'b0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      out_eol_q    <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_col_q     <= rd_col_d;
      fetch_done_q <= fetch_done_d;
      out_pixel_q  <= out_pixel_d;
      out_valid_q  <= out_valid_d;
      out_eol_q    <= out_eol_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  // Frame buffer: contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_addr_q] <= sat_pix_c;
    end
  end

`ifdef SINK_CLIP_COUNT_EN
  logic [15:0] clip_count_q, clip_count_d;

  // Saturating count of clipped writes, cleared as the next capture begins
  always_comb begin
    clip_count_d = clip_count_q;
    if (frame_end_c) begin
      clip_count_d = '0;
    end else if (wr_en_c && (clip_lo_c || clip_hi_c) && (clip_count_q != 16'hFFFF)) begin
      clip_count_d = clip_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clip_count_q <= '0;
    end else begin
      clip_count_q <= clip_count_d;
    end
  end

  assign clip_count = clip_count_q;
`else
  assign clip_count = '0;
`endif

  assign out_pixel    = out_pixel_q;
  assign out_valid    = out_valid_q;
  assign out_eol      = out_eol_q;
  assign out_last     = out_last_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_sharpened_frame_sink.sv
// Directed bench for sharpened_frame_sink on a 4x4 frame: ramp, saturation, backpressure,
// sparse input, overflow and mid-drain reset.
module tb_sharpened_frame_sink;

  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned IN_W  = 10;
  localparam int unsigned PIX_W = 8;
  localparam int NPIX = 16;

  logic             clk;
  logic             rst_n;
  logic [IN_W-1:0]  in_pixel;
  logic             in_en;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             out_eol;
  logic             out_last;
  logic             frame_done;
  logic             busy;
  logic             overflow_err;
  logic [15:0]      clip_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IN_W-1:0]  stim [NPIX];
  logic [PIX_W-1:0] expd [NPIX];

  sharpened_frame_sink #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IN_W(IN_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_en(in_en),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_last(out_last), .frame_done(frame_done),
    .busy(busy), .overflow_err(overflow_err), .clip_count(clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input bit reversed);
    for (int i = 0; i < NPIX; i++) begin
      stim[i] = reversed ? IN_W'(15 - i) : IN_W'(i);
      expd[i] = reversed ? PIX_W'(15 - i) : PIX_W'(i);
    end
  endtask

  // Feed 16 samples with 'gap' idle cycles between them
  task automatic capture(input int gap);
    for (int i = 0; i < NPIX; i++) begin
      if (i == NPIX - 1) check_eq("busy_before_last", 32'(busy), 32'd0);
      in_en    = 1'b1;
      in_pixel = stim[i];
      tick();
      in_en = 1'b0;
      if (i != NPIX - 1) repeat (gap) tick();
    end
    check_eq("busy_after_last", 32'(busy), 32'd1);
  endtask

  // Accept n pixels; mode 0 = ready always, mode 1 = ready pattern 1,0,0,1
  task automatic drain(input int mode, input int n);
    int got = 0;
    int cyc = 0;
    logic held_v = 1'b0;
    logic [PIX_W+1:0] held = '0;
    while (got < n && cyc < 200) begin
      if (held_v) check_eq("stall_hold", 32'({out_valid, out_last, out_eol, out_pixel}), 32'({1'b1, held}));
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      held_v = out_valid && !out_ready;
      held   = {out_last, out_eol, out_pixel};
      if (out_valid && out_ready) begin
        check_eq("pixel", 32'(out_pixel), 32'(expd[got]));
        check_eq("eol", 32'(out_eol), 32'(got % 4 == 3));
        check_eq("last", 32'(out_last), 32'(got == NPIX - 1));
        got++;
      end
      tick();
      cyc++;
    end
    if (got < n) check_eq("drain_timeout", 32'(got), 32'(n));
    out_ready = 1'b0;
    if (n == NPIX) begin
      check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
      check_eq("valid_after_last", 32'(out_valid), 32'd0);
      check_eq("busy_after_frame", 32'(busy), 32'd0);
      check_eq("clip_cleared", 32'(clip_count), 32'd0);
      tick();
      check_eq("frame_done_single", 32'(frame_done), 32'd0);
      check_eq("valid_in_capture", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_en     = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_flags", 32'({out_eol, out_last, frame_done, busy, overflow_err}), 32'd0);
    check_eq("rst_clip", 32'(clip_count), 32'd0);
    check_eq("rst_pixel", 32'(out_pixel), 32'd0);
    rst_n = 1'b1;
    tick();

    // Ramp, continuous input, ready high
    set_ramp(1'b0);
    capture(0);
    check_eq("drain_entry_no_valid", 32'(out_valid), 32'd0);
    tick();
    check_eq("first_valid_latency", 32'(out_valid), 32'd1);
    drain(0, NPIX);

    // Saturation
    stim[0] = 10'h3FB; expd[0] = 8'd0;
    stim[1] = 10'd300; expd[1] = 8'd255;
    stim[2] = 10'd255; expd[2] = 8'd255;
    stim[3] = 10'd0;   expd[3] = 8'd0;
    stim[4] = 10'h200; expd[4] = 8'd0;
    stim[5] = 10'h1FF; expd[5] = 8'd255;
    for (int i = 6; i < NPIX; i++) begin
      stim[i] = IN_W'(i + 20);
      expd[i] = PIX_W'(i + 20);
    end
    capture(0);
`ifdef SINK_CLIP_COUNT_EN
    check_eq("clip_count", 32'(clip_count), 32'd4);
`else
    check_eq("clip_count", 32'(clip_count), 32'd0);
`endif
    drain(0, NPIX);

    // Backpressure
    set_ramp(1'b0);
    capture(0);
    drain(1, NPIX);

    // Sparse input, every third cycle
    capture(2);
    drain(0, NPIX);

    // Overflow while draining
    capture(0);
    check_eq("overflow_clear_before", 32'(overflow_err), 32'd0);
    in_en    = 1'b1;
    in_pixel = 10'd77;
    tick();
    in_en = 1'b0;
    check_eq("overflow_set", 32'(overflow_err), 32'd1);
    drain(0, NPIX);
    check_eq("overflow_sticky", 32'(overflow_err), 32'd1);
    set_ramp(1'b1);
    capture(0);
    drain(1, NPIX);
    check_eq("overflow_sticky2", 32'(overflow_err), 32'd1);

    // Reset after 5 accepted pixels
    set_ramp(1'b0);
    capture(0);
    drain(0, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_no_done", 32'(frame_done), 32'd0);
    check_eq("mid_rst_overflow", 32'(overflow_err), 32'd0);
    tick();
    check_eq("mid_rst_no_done2", 32'(frame_done), 32'd0);
    set_ramp(1'b1);
    capture(0);
    drain(0, NPIX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
